// File: rtl/idecode_regfile_mp.sv
// rtl/idecode_regfile_mp.sv - decode-stage register file with link port, bypass and busy scoreboard
//
// Ports:
//   clock, reset            rising-edge clock; asynchronous active-low clear of all state
//   rs_addr/rt_addr         read addresses; rs_used/rt_used mark operands the instruction consumes
//   rd_data_1/rd_data_2     combinational read data
//   wb_en/wb_addr/wb_data   write-back port
//   link_en/link_data       return-address write into LINK_REG
//   issue_en/issue_addr     destination of an instruction issued this cycle (marks it busy)
//   rs_busy/rt_busy/stall   operand hazard status; busy_vec exposes the whole scoreboard
module idecode_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [REG_AW-1:0]        rs_addr,
  input  logic [REG_AW-1:0]        rt_addr,
  input  logic                     rs_used,
  input  logic                     rt_used,
  output logic [DATA_W-1:0]        rd_data_1,
  output logic [DATA_W-1:0]        rd_data_2,
  input  logic                     wb_en,
  input  logic [REG_AW-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     link_en,
  input  logic [DATA_W-1:0]        link_data,
  input  logic                     issue_en,
  input  logic [REG_AW-1:0]        issue_addr,
  output logic                     rs_busy,
  output logic                     rt_busy,
  output logic                     stall,
  output logic [(2**REG_AW)-1:0]   busy_vec
);

  localparam int NREG = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] LINK_A = LINK_REG[REG_AW-1:0];
  localparam bit BYP  = (BYPASS != 0);
  localparam bit ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [NREG];

  // Effective write strobes. The link port wins a collision on LINK_REG, so the
  // write-back is dropped entirely (no array write, no scoreboard clear).
  logic link_ok;
  logic wb_ok;

  assign link_ok = link_en && !(ZERO && (LINK_A == '0));
  assign wb_ok   = wb_en && !(link_en && (wb_addr == LINK_A)) && !(ZERO && (wb_addr == '0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_ok)   regs[wb_addr] <= wb_data;
      if (link_ok) regs[LINK_A]  <= link_data;
    end
  end

  // Scoreboard: a new issue to the same register beats a completing write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_vec <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ZERO && i == 0)
          busy_vec[i] <= 1'b0;
        else if (issue_en && issue_addr == REG_AW'(i))
          busy_vec[i] <= 1'b1;
        else if ((wb_ok && wb_addr == REG_AW'(i)) || (link_ok && LINK_A == REG_AW'(i)))
          busy_vec[i] <= 1'b0;
      end
    end
  end

  // Read ports with optional same-cycle forwarding; a forwarded register is
  // also treated as no longer busy since its value is available now.
  logic [REG_AW-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic [1:0]        hit_link;
  logic [1:0]        hit_wb;
  logic [1:0]        busy_p;

  assign raddr[0] = rs_addr;
  assign raddr[1] = rt_addr;

  always_comb begin
    hit_link = '0;
    hit_wb   = '0;
    busy_p   = '0;
    for (int p = 0; p < 2; p++) begin
      rdata[p]    = regs[raddr[p]];
      hit_link[p] = BYP && link_ok && (raddr[p] == LINK_A);
      hit_wb[p]   = BYP && wb_ok && (raddr[p] == wb_addr);
      if (ZERO && raddr[p] == '0)
        rdata[p] = '0;
      else if (hit_link[p])
        rdata[p] = link_data;
      else if (hit_wb[p])
        rdata[p] = wb_data;
      busy_p[p] = busy_vec[raddr[p]] && !(hit_link[p] || hit_wb[p]);
    end
  end

  assign rd_data_1 = rdata[0];
  assign rd_data_2 = rdata[1];
  assign rs_busy   = busy_p[0];
  assign rt_busy   = busy_p[1];
  assign stall     = (rs_used && rs_busy) || (rt_used && rt_busy);

endmodule

// File: doc/idecode_regfile_mp.md
# idecode_regfile_mp

Parametrised register-file and hazard-scoreboard block for the decode stage of the Minisys-1A pipeline; the next generation of the decode register file. It provides two combinational read ports, a write-back port, a dedicated link-write port (jal/jalr/bgezal/bltzal return address), optional write-through bypass, and a per-register busy scoreboard that raises a stall when a source operand has an outstanding producer. It sits between IF/ID and ID/EX and takes write-back from the WB stage.

## Interface

- DATA_W, 32, register data width
- REG_AW, 5, register address width; register count is 2**REG_AW
- LINK_REG, 31, register index written by the link port
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports and busy masked; 0 = no forwarding
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

- clock  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- rs_addr  in  REG_AW  read port 1 address
- rt_addr  in  REG_AW  read port 2 address
- rs_used  in  1  current instruction consumes rs
- rt_used  in  1  current instruction consumes rt
- rd_data_1  out  DATA_W  read port 1 data
- rd_data_2  out  DATA_W  read port 2 data
- wb_en  in  1  write-back write enable
- wb_addr  in  REG_AW  write-back address
- wb_data  in  DATA_W  write-back data
- link_en  in  1  link write enable (target LINK_REG)
- link_data  in  DATA_W  link value (PC+4 of linking instruction)
- issue_en  in  1  instruction issued this cycle with a destination
- issue_addr  in  REG_AW  destination of issued instruction
- rs_busy  out  1  rs has an outstanding producer
- rt_busy  out  1  rt has an outstanding producer
- stall  out  1  (rs_used & rs_busy) | (rt_used & rt_busy)
- busy_vec  out  2**REG_AW  scoreboard bits, bit i = register i busy

## Operation

- Storage: 2**REG_AW x DATA_W array, written on rising clock edge.
- Write ports: wb_en writes wb_data to wb_addr; link_en writes link_data to LINK_REG.
- Write collision (wb_en & link_en & wb_addr == LINK_REG): link wins; wb write dropped.
- ZERO_REG=1: writes to address 0 discarded; reads of address 0 return 0 regardless of bypass.
- Read: combinational array read of rs_addr/rt_addr.
- BYPASS=1: if a write to the read address is enabled in the same cycle, the read returns the winning write data (link over wb per collision rule).
- Scoreboard, per register i at rising edge:
  - set if issue_en & issue_addr == i;
  - else clear if (wb_en & wb_addr == i & not dropped by collision) or (link_en & i == LINK_REG);
  - else hold.
  - Set beats clear (a new producer replaces the completing one).
  - ZERO_REG=1: bit 0 held at 0.
- rs_busy = busy_vec[rs_addr], masked to 0 when BYPASS=1 and a winning write to rs_addr is enabled this cycle; same rule for rt_busy.
- stall is purely combinational from the above; block does not itself hold issue_en — the issue controller must not assert issue_en while stall=1.

## Timing

- Reset (reset=0, asynchronous): all registers 0, busy_vec all 0; consequently rd_data_1/2 = 0, rs_busy = rt_busy = stall = 0 while in reset and after release until written/issued. Release synchronously effective at next rising edge.
- Reset asserted mid-write: write lost, array and scoreboard clear immediately.
- Write latency: data visible on read ports 0 cycles after enable with BYPASS=1, 1 cycle (after the edge) with BYPASS=0.
- Busy latency: bit visible from cycle after issue_en edge; clear visible same cycle (BYPASS=1) or next cycle (BYPASS=0).
- Read ports, busy, stall: no register stage; all outputs combinational from inputs and state.

## Test plan

- Reset then read: reset=0 for 2 cycles, release; rs_addr=8, rt_addr=31 -> rd_data_1=rd_data_2=0, busy_vec=0, stall=0.
- Write/read and bypass: wb_en=1, wb_addr=8, wb_data=32'hffff0000, rs_addr=8 -> BYPASS=1: rd_data_1=32'hffff0000 same cycle; BYPASS=0: 0 same cycle, 32'hffff0000 after edge.
- Zero register: wb_en=1, wb_addr=0, wb_data=32'h00000030; issue_en=1, issue_addr=0 -> rd_data of addr 0 stays 0, busy_vec[0]=0.
- Link collision: link_en=1, link_data=32'h0000000a, wb_en=1, wb_addr=31, wb_data=32'h12345678 -> after edge reg31=32'h0000000a.
- Scoreboard hazard: issue_en=1, issue_addr=10; next cycle rs_addr=10, rs_used=1 -> rs_busy=1, stall=1; then wb_en=1, wb_addr=10, wb_data=32'hffff003d -> BYPASS=1: stall=0 and rd_data_1=32'hffff003d same cycle; busy_vec[10]=0 after edge.
- Set beats clear and async reset: issue_en & wb_en both on addr 9 -> busy_vec[9]=1 after edge; then reset=0 mid-cycle -> busy_vec=0 and register 9 reads 0 immediately.
